edge_window_loader: RTL
=======================

# edge_window_loader

Upstream feeder for the 3x3-output edge detection core. Accepts a serial byte stream of 5x5 pixel tiles in raster order and assembles each tile into 25 held window registers. It then pulses the core's start, stalls the stream until the core's ready completes, and repeats for the next tile. An optional watchdog aborts a tile whose completion never arrives.

## Interface
Parameters:
- TIMEOUT_CYCLES, 200: watchdog limit in cycles, counted from entry to START. Used only with WINDOW_LOADER_TIMEOUT_EN.
- TIMEOUT_W, 8: watchdog counter width. Requires TIMEOUT_CYCLES < 2^TIMEOUT_W.

Ports:
- clk  in  1  single clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- i_pixel  in  8  stream pixel, unsigned.
- i_pixel_valid  in  1  i_pixel is valid this cycle.
- o_pixel_ready  out  1  loader accepts a pixel this cycle.
- i_gradient_ready  in  1  core completion level; connects to the core's o_gradient_ready.
- o_gradient_start  out  1  one-cycle start pulse to the core.
- o_m1 … o_m25  out  8 each  window registers; connect to core i_m1 … i_m25.
- o_tile_done  out  1  one-cycle pulse on tile completion.
- o_busy  out  1  high in START or WAIT.
- o_timeout  out  1  sticky watchdog flag.

## Operation
- FSM states and transitions:
  - LOAD is the reset state. Go to START on the edge that accepts pixel 25.
  - START lasts exactly 1 cycle, then go to WAIT.
  - WAIT: go to LOAD on completion, or on timeout when enabled.
- Accept occurs on an edge where i_pixel_valid && o_pixel_ready.
- o_pixel_ready = (state == LOAD). It is combinational from the state register and does not depend on i_pixel_valid.
- Index counter:
  - 5 bits, range 0..24, reset 0.
  - The pixel accepted at index k is written to o_m(k+1). The counter then increments.
  - The counter wraps to 0 on the accept at index 24.
- Window registers change only on an accept. They are stable throughout START and WAIT. During LOAD they hold a mix of the new tile and the previous tile, which is harmless because the core samples only after start.
- o_gradient_start = (state == START). o_busy = (state == START || state == WAIT).
- Completion detection:
  - A register rdy_q samples i_gradient_ready every cycle. rdy_q resets to 0.
  - Completion = i_gradient_ready && !rdy_q, sampled in START or WAIT. This is a rising edge.
  - A level already held high from the previous tile does not complete the new tile.
  - Rising edges seen in LOAD are ignored.
- o_tile_done is registered and goes high for 1 cycle after the completion edge. The same edge returns the state to LOAD.
- Reset mid-operation (n_rst low at any time) applies immediately:
  - state = LOAD, counter = 0, all o_m = 0, rdy_q = 0.
  - o_gradient_start, o_tile_done and o_timeout = 0.
- Reset values of all outputs: o_m1..o_m25 = 0, o_gradient_start = 0, o_tile_done = 0, o_busy = 0, o_timeout = 0, o_pixel_ready = 1.

## Timing
- Minimum tile period: 25 accept cycles + 1 START cycle + core latency + 1.
- Edge E accepts pixel 25:
  - o_pixel_ready goes low and o_gradient_start goes high for the cycle after E.
  - At edge E+1, o_gradient_start falls.
- Completion at edge C:
  - o_tile_done is high for the cycle after C.
  - o_pixel_ready is high in that same cycle, so the first pixel of the next tile can be accepted at edge C+1.
- If completion and timeout occur on the same edge, completion wins: no timeout is flagged.
- i_pixel_valid asserted outside LOAD has no effect. The upstream source must hold i_pixel until it is accepted.

## Configuration
- WINDOW_LOADER_TIMEOUT_EN defined:
  - A TIMEOUT_W-bit counter clears on entry to START and increments each cycle in START/WAIT.
  - When the counter reaches TIMEOUT_CYCLES without completion, o_timeout is set and the state returns to LOAD. The counter is already 0.
  - No o_tile_done is issued for the aborted tile.
  - o_timeout stays high until reset.
- Not defined:
  - No watchdog logic.
  - o_timeout is tied 0.
  - WAIT persists until completion.

## Test plan
- Reset with n_rst low → all o_m = 0, o_pixel_ready = 1, o_busy = 0, o_gradient_start = 0, o_timeout = 0.
- Stream pixels 1..25 with continuous valid → o_m1 = 1 … o_m25 = 25. o_gradient_start is high exactly 1 cycle, the cycle after the 25th accept. o_pixel_ready = 0 and o_busy = 1 from then on.
- Valid toggled every other cycle with values 0xA0..0xB8 → o_m1 = 0xA0 … o_m25 = 0xB8. Only accepted beats are counted. Start comes 1 cycle after the 25th accept.
- Drive i_gradient_ready high 6 cycles after start and hold it for 10 cycles → one o_tile_done pulse and o_pixel_ready = 1 in the same cycle. Load a second tile while i_gradient_ready is still high → no completion until i_gradient_ready falls and rises again.
- Reset asserted after 10 accepts, then 25 new pixels 0x01..0x19 → o_m values match the new stream. Start occurs after exactly 25 post-reset accepts.
- With the macro and TIMEOUT_CYCLES = 16, i_gradient_ready held 0 → o_timeout = 1 and o_pixel_ready = 1 on the 16th edge after START entry, with no o_tile_done; o_timeout stays set. Without the macro → o_busy remains 1 indefinitely and o_timeout = 0.

Source files
------------

// File: rtl/edge_window_loader.sv
// Collects a 5x5 raster tile into 25 window registers, pulses start to the edge core, then
// waits for the core's ready rising edge. WINDOW_LOADER_TIMEOUT_EN adds a watchdog that aborts a stuck tile.
module edge_window_loader #(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TIMEOUT_W      = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] i_pixel,
  input  logic       i_pixel_valid,
  output logic       o_pixel_ready,
  input  logic       i_gradient_ready,
  output logic       o_gradient_start,
  output logic [7:0] o_m1,  output logic [7:0] o_m2,  output logic [7:0] o_m3,
  output logic [7:0] o_m4,  output logic [7:0] o_m5,  output logic [7:0] o_m6,
  output logic [7:0] o_m7,  output logic [7:0] o_m8,  output logic [7:0] o_m9,
  output logic [7:0] o_m10, output logic [7:0] o_m11, output logic [7:0] o_m12,
  output logic [7:0] o_m13, output logic [7:0] o_m14, output logic [7:0] o_m15,
  output logic [7:0] o_m16, output logic [7:0] o_m17, output logic [7:0] o_m18,
  output logic [7:0] o_m19, output logic [7:0] o_m20, output logic [7:0] o_m21,
  output logic [7:0] o_m22, output logic [7:0] o_m23, output logic [7:0] o_m24,
  output logic [7:0] o_m25,
  output logic       o_tile_done,
  output logic       o_busy,
  output logic       o_timeout
);

  typedef enum logic [1:0] {LOAD = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] m_q [25];
  logic       rdy_q;
  logic       tile_done_q;
  logic       accept, last_accept, complete, abort;

  if (TIMEOUT_CYCLES >= (2 ** TIMEOUT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit in TIMEOUT_W bits");
  end

  assign accept      = i_pixel_valid && (state_q == LOAD);
  assign last_accept = accept && (idx_q == 5'd24);
  // Only a fresh rising edge counts, so a level left high by the previous tile is ignored.
  assign complete    = (state_q != LOAD) && i_gradient_ready && !rdy_q;
  assign idx_d       = last_accept ? 5'd0 : (accept ? idx_q + 5'd1 : idx_q);

`ifdef WINDOW_LOADER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout_q;

  assign abort = (state_q != LOAD) && !complete &&
                 (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (last_accept || abort) cnt_d = '0;
    else if (state_q != LOAD) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | abort;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign abort     = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:        if (last_accept) state_d = START;
      START, WAIT: state_d = (complete || abort) ? LOAD : WAIT;
      default:     state_d = LOAD;
    endcase
  end

  always_comb begin
    o_pixel_ready    = (state_q == LOAD);
    o_gradient_start = (state_q == START);
    o_busy           = (state_q == START) || (state_q == WAIT);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_q       <= 5'd0;
      rdy_q       <= 1'b0;
      tile_done_q <= 1'b0;
      for (int i = 0; i < 25; i++) m_q[i] <= 8'd0;
    end else begin
      idx_q       <= idx_d;
      rdy_q       <= i_gradient_ready;
      tile_done_q <= complete;
      if (accept) m_q[idx_q] <= i_pixel;
    end
  end

  assign o_tile_done = tile_done_q;

  assign o_m1  = m_q[0];  assign o_m2  = m_q[1];  assign o_m3  = m_q[2];
  assign o_m4  = m_q[3];  assign o_m5  = m_q[4];  assign o_m6  = m_q[5];
  assign o_m7  = m_q[6];  assign o_m8  = m_q[7];  assign o_m9  = m_q[8];
  assign o_m10 = m_q[9];  assign o_m11 = m_q[10]; assign o_m12 = m_q[11];
  assign o_m13 = m_q[12]; assign o_m14 = m_q[13]; assign o_m15 = m_q[14];
  assign o_m16 = m_q[15]; assign o_m17 = m_q[16]; assign o_m18 = m_q[17];
  assign o_m19 = m_q[18]; assign o_m20 = m_q[19]; assign o_m21 = m_q[20];
  assign o_m22 = m_q[21]; assign o_m23 = m_q[22]; assign o_m24 = m_q[23];
  assign o_m25 = m_q[24];

endmodule
